decode_multilane: RTL and testbench
===================================

// Module: decode_multilane
// PURPOSE
//  DECODE_WIDTH-lane RV64IM decoder between fetch queue and rename. Registers one
//  decinfo_t per lane into a BUF_DEPTH-entry bundle FIFO with valid/ready on both sides.
//  Classifies nop (addi rd,rd,0) and mv (addi rd,rs1,0, rd!=rs1) for move elimination.
//  Truncates each bundle at the first illegal/ecall/ebreak lane.
// PARAMETERS
//  DECODE_WIDTH  4  lanes per bundle (1..8)
//  BUF_DEPTH     2  decoded bundles buffered (power of 2, >=2)
// PORTS
//  clk              in   1                     clock
//  rst              in   1                     synchronous reset, active-high
//  i_flush          in   1                     squash all buffered and incoming bundles
//  if_valid         in   1                     input bundle valid
//  if_ready         out  1                     decoder can accept a bundle
//  if_vld_mask      in   DECODE_WIDTH          per-lane valid, contiguous from lane 0
//  if_pc            in   DECODE_WIDTH*PCDEF    per-lane pc
//  if_inst          in   DECODE_WIDTH*32       per-lane raw instruction
//  o_valid          out  1                     output bundle valid
//  o_ready          in   1                     rename accepts output bundle
//  o_vld_mask       out  DECODE_WIDTH          per-lane valid after truncation
//  o_decinfo        out  DECODE_WIDTH*decinfo_t decoded lanes
//  o_exc_valid      out  1                     bundle ends in an excepting lane
//  o_exc_lane       out  clog2(DECODE_WIDTH)   index of excepting lane
//  o_exc_code       out  2                     0 illegal, 1 ecall, 2 ebreak
// BEHAVIOUR
//  Reset: FIFO empty, pointers 0; o_valid=0, o_vld_mask=0, o_exc_valid=0, o_exc_lane=0,
//   o_exc_code=0, o_decinfo=0; if_ready=0 while rst, 1 the cycle after.
//  Handshake: push when if_valid&&if_ready; pop when o_valid&&o_ready. Whole bundles only.
//  if_ready = !rst && !i_flush && count<BUF_DEPTH (no comb path from o_ready; full+pop
//   still reports not ready that cycle). Latency: accepted cycle N -> o_valid in N+1
//   when FIFO empty. o_* are read from head entry; stable while o_valid&&!o_ready.
//  Flush: i_flush clears count/pointers next cycle, drops incoming bundle, o_valid=0 next cycle.
//  Flush and rst override push/pop in the same cycle.
//  Lane decode (combinational, per lane, registered into FIFO):
//   - inst[1:0]!=2'b11, unknown opcode, unknown funct3/funct7 -> illegal.
//   - LUI/AUIPC/JAL/JALR -> fu=misc, micOp lui/auipc/jal/jalr.
//   - BRANCH -> fu=alu, beq/bne/blt/bge; BLTU/BGEU use blt/bge with csr_idx[0]=1 (unsigned).
//   - LOAD lb..ld,lbu/lhu/lwu -> ldu; STORE sb..sd -> stu; OP/OPIMM (+W forms) -> alu;
//     OPC_64IM/OP funct7=0000001 -> mdu.
//   - CSRRW/S/C(+I) -> fu=misc, csr_en=1, csr_idx=inst[31:20]; immediate forms put zimm in rs1.
//   - FENCE/FENCE.I -> fu=nop, rd_wen=0. ECALL/EBREAK -> exception lane.
//   - addi rd,rd,0 (incl. x0) -> fu=nop, rd_wen=0; addi rd,rs1,0 with rd!=rs1 -> fu=mv.
//   - rd_wen=1 only for rd-writing classes with rd!=0.
//   - imm20: I/S 12b sign-extended; U inst[31:12]; B imm[12:1] and J imm[20:1]
//     sign-extended to 20b (bit0 implicit 0).
//  Truncation: first valid lane k with exception -> o_vld_mask keeps lanes 0..k (lane k valid,
//   fu=none), lanes >k cleared; o_exc_valid=1, o_exc_lane=k. Lanes with if_vld_mask=0 ignored.
//  Pointers wrap modulo BUF_DEPTH; count 0..BUF_DEPTH.
// TESTING
//  1) rst 2 cycles, then bundle {addi x5,x5,0; addi x6,x7,0; add x1,x2,x3; lui x4,0x12345}
//     -> next cycle o_valid=1, mask 4'b1111, fu {nop,mv,alu,misc}, lane3 imm20=20'h12345.
//  2) o_ready=0, push 2 bundles -> if_ready=0 after 2nd; 3rd held; o_ready=1 -> bundles
//     emerge in order, contents unchanged during stall.
//  3) lanes {add; 32'h0000_0000; ecall; add} -> o_vld_mask=4'b0011, o_exc_valid=1,
//     o_exc_lane=1, o_exc_code=0.
//  4) beq offset -4096 and jal offset +2 -> imm20 20'hFF800 and 20'h00001.
//  5) FIFO full + if_valid + i_flush -> next cycle o_valid=0, if_ready=1, nothing buffered.
//  6) rst asserted mid-stream with o_valid=1 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/decode_multilane_if.sv
// Bundle interface between fetch queue, multilane decoder and rename.
//   Fetch side : if_valid/if_ready handshake, per-lane valid mask, pc and raw instruction.
//   Rename side: o_valid/o_ready handshake, truncated lane mask, packed decoded lanes and
//                the exception summary (valid, lane index, code).
// Modports: master = environment (fetch + rename), slave = decoder.
// Decoded lane layout (MSB to LSB, DEC_W = PCDEF + 59 bits per lane, lane 0 at the LSBs):
//   pc[PCDEF], fu[3], micop[5], is_word, use_imm, rd[5], rd_wen, rs1[5], rs2[5],
//   imm20[20], csr_en, csr_idx[12]
interface decode_multilane_if #(
  parameter int unsigned DECODE_WIDTH = 4,
  parameter int unsigned PCDEF        = 64
);
  localparam int unsigned DEC_W  = PCDEF + 59;
  localparam int unsigned LANE_W = (DECODE_WIDTH > 1) ? $clog2(DECODE_WIDTH) : 1;

  logic                          if_valid;
  logic                          if_ready;
  logic [DECODE_WIDTH-1:0]       if_vld_mask;
  logic [DECODE_WIDTH*PCDEF-1:0] if_pc;
  logic [DECODE_WIDTH*32-1:0]    if_inst;

  logic                          o_valid;
  logic                          o_ready;
  logic [DECODE_WIDTH-1:0]       o_vld_mask;
  logic [DECODE_WIDTH*DEC_W-1:0] o_decinfo;
  logic                          o_exc_valid;
  logic [LANE_W-1:0]             o_exc_lane;
  logic [1:0]                    o_exc_code;

  modport master (
    output if_valid, if_vld_mask, if_pc, if_inst, o_ready,
    input  if_ready, o_valid, o_vld_mask, o_decinfo, o_exc_valid, o_exc_lane, o_exc_code
  );

  modport slave (
    input  if_valid, if_vld_mask, if_pc, if_inst, o_ready,
    output if_ready, o_valid, o_vld_mask, o_decinfo, o_exc_valid, o_exc_lane, o_exc_code
  );
endinterface

// File: rtl/decode_multilane.sv
// DECODE_WIDTH-lane RV64IM decoder. Each accepted fetch bundle is decoded combinationally,
// truncated at the first valid excepting lane and written into a BUF_DEPTH-entry bundle FIFO;
// rename reads the head entry.
// Ports:
//   clk      clock
//   rst      synchronous reset, active-high
//   i_flush  drop all buffered bundles and the bundle offered this cycle
//   bus      decode_multilane_if.slave (fetch-side and rename-side bundle signals)
// fu codes   : 0 none, 1 alu, 2 mdu, 3 ldu, 4 stu, 5 misc, 6 mv, 7 nop
// micop codes: alu 0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and,
//              10 beq,11 bne,12 blt,13 bge; mdu/ldu/stu use funct3;
//              misc 16 lui,17 auipc,18 jal,19 jalr,20 csrrw,21 csrrs,22 csrrc
// Exception codes: 0 illegal, 1 ecall, 2 ebreak.
module decode_multilane #(
  parameter int unsigned DECODE_WIDTH = 4,
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned PCDEF        = 64
) (
  input logic                clk,
  input logic                rst,
  input logic                i_flush,
  decode_multilane_if.slave  bus
);

  localparam int unsigned LaneW = (DECODE_WIDTH > 1) ? $clog2(DECODE_WIDTH) : 1;
  localparam int unsigned PtrW  = $clog2(BUF_DEPTH);
  localparam int unsigned CntW  = $clog2(BUF_DEPTH + 1);

  localparam logic [2:0] FuNone = 3'd0;
  localparam logic [2:0] FuAlu  = 3'd1;
  localparam logic [2:0] FuMdu  = 3'd2;
  localparam logic [2:0] FuLdu  = 3'd3;
  localparam logic [2:0] FuStu  = 3'd4;
  localparam logic [2:0] FuMisc = 3'd5;
  localparam logic [2:0] FuMv   = 3'd6;
  localparam logic [2:0] FuNop  = 3'd7;

  localparam logic [4:0] MicAdd   = 5'd0;
  localparam logic [4:0] MicSub   = 5'd1;
  localparam logic [4:0] MicSll   = 5'd2;
  localparam logic [4:0] MicSrl   = 5'd6;
  localparam logic [4:0] MicSra   = 5'd7;
  localparam logic [4:0] MicBeq   = 5'd10;
  localparam logic [4:0] MicBne   = 5'd11;
  localparam logic [4:0] MicBlt   = 5'd12;
  localparam logic [4:0] MicBge   = 5'd13;
  localparam logic [4:0] MicLui   = 5'd16;
  localparam logic [4:0] MicAuipc = 5'd17;
  localparam logic [4:0] MicJal   = 5'd18;
  localparam logic [4:0] MicJalr  = 5'd19;
  localparam logic [4:0] MicCsrrw = 5'd20;

  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] Opc64Im    = 7'b0111011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  typedef struct packed {
    logic [PCDEF-1:0] pc;
    logic [2:0]       fu;
    logic [4:0]       micop;
    logic             is_word;
    logic             use_imm;
    logic [4:0]       rd;
    logic             rd_wen;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [19:0]      imm20;
    logic             csr_en;
    logic [11:0]      csr_idx;
  } decinfo_t;

  typedef struct packed {
    decinfo_t   info;
    logic       exc;
    logic [1:0] code;
  } lane_t;

  typedef struct packed {
    logic [DECODE_WIDTH-1:0]     mask;
    decinfo_t [DECODE_WIDTH-1:0] info;
    logic                        exc_valid;
    logic [LaneW-1:0]            exc_lane;
    logic [1:0]                  exc_code;
  } bundle_t;

  // Base ALU op for OP/OP-IMM with funct7 = 0 (sub/sra handled by the caller).
  function automatic logic [4:0] alu_op(input logic [2:0] f3);
    logic [4:0] op;
    unique case (f3)
      3'd0:    op = 5'd0;
      3'd1:    op = 5'd2;
      3'd2:    op = 5'd3;
      3'd3:    op = 5'd4;
      3'd4:    op = 5'd5;
      3'd5:    op = 5'd6;
      3'd6:    op = 5'd8;
      default: op = 5'd9;
    endcase
    return op;
  endfunction

  function automatic lane_t decode_lane(input logic [31:0] inst, input logic [PCDEF-1:0] pc);
    lane_t       r;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm_i;
    logic        rd_writes;
    logic        ill;
    logic        is_ecall;
    logic        is_ebreak;

    r              = '0;
    r.info.pc      = pc;
    r.info.rd      = inst[11:7];
    r.info.rs1     = inst[19:15];
    r.info.rs2     = inst[24:20];
    opc            = inst[6:0];
    f3             = inst[14:12];
    f7             = inst[31:25];
    imm_i          = inst[31:20];
    rd_writes      = 1'b0;
    ill            = (inst[1:0] != 2'b11);
    is_ecall       = 1'b0;
    is_ebreak      = 1'b0;

    case (opc)
      OpcLui, OpcAuipc: begin
        r.info.fu    = FuMisc;
        r.info.micop = (opc == OpcLui) ? MicLui : MicAuipc;
        r.info.imm20 = inst[31:12];
        rd_writes    = 1'b1;
      end
      OpcJal: begin
        r.info.fu    = FuMisc;
        r.info.micop = MicJal;
        r.info.imm20 = {inst[31], inst[19:12], inst[20], inst[30:21]};
        rd_writes    = 1'b1;
      end
      OpcJalr: begin
        r.info.fu    = FuMisc;
        r.info.micop = MicJalr;
        r.info.imm20 = {{8{inst[31]}}, imm_i};
        rd_writes    = 1'b1;
        ill          = ill | (f3 != 3'd0);
      end
      OpcBranch: begin
        r.info.fu    = FuAlu;
        r.info.imm20 = {{8{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8]};
        // Unsigned compares reuse blt/bge; csr_idx[0] flags the unsigned variant.
        r.info.csr_idx[0] = f3[1];
        case (f3)
          3'd0:       r.info.micop = MicBeq;
          3'd1:       r.info.micop = MicBne;
          3'd4, 3'd6: r.info.micop = MicBlt;
          3'd5, 3'd7: r.info.micop = MicBge;
          default:    ill = 1'b1;
        endcase
      end
      OpcLoad: begin
        r.info.fu    = FuLdu;
        r.info.micop = {2'b00, f3};
        r.info.imm20 = {{8{inst[31]}}, imm_i};
        rd_writes    = 1'b1;
        ill          = ill | (f3 == 3'd7);
      end
      OpcStore: begin
        r.info.fu    = FuStu;
        r.info.micop = {2'b00, f3};
        r.info.imm20 = {{8{inst[31]}}, inst[31:25], inst[11:7]};
        ill          = ill | f3[2];
      end
      OpcOpImm: begin
        r.info.fu      = FuAlu;
        r.info.use_imm = 1'b1;
        r.info.micop   = alu_op(f3);
        r.info.imm20   = {{8{inst[31]}}, imm_i};
        rd_writes      = 1'b1;
        if (f3 == 3'd1) begin
          ill = ill | (inst[31:26] != 6'd0);
        end else if (f3 == 3'd5) begin
          if (inst[31:26] == 6'b010000) r.info.micop = MicSra;
          else if (inst[31:26] != 6'd0) ill = 1'b1;
        end
        // addi with zero immediate: self-move is a nop, otherwise an eliminable move.
        if (f3 == 3'd0 && imm_i == 12'd0) begin
          if (inst[11:7] == inst[19:15]) begin
            r.info.fu = FuNop;
            rd_writes = 1'b0;
          end else begin
            r.info.fu = FuMv;
          end
        end
      end
      OpcOpImm32: begin
        r.info.fu      = FuAlu;
        r.info.is_word = 1'b1;
        r.info.use_imm = 1'b1;
        r.info.imm20   = {{8{inst[31]}}, imm_i};
        rd_writes      = 1'b1;
        case (f3)
          3'd0: r.info.micop = MicAdd;
          3'd1: begin
            r.info.micop = MicSll;
            ill          = ill | (f7 != 7'd0);
          end
          3'd5: begin
            if (f7 == 7'b0100000) r.info.micop = MicSra;
            else if (f7 == 7'd0) r.info.micop = MicSrl;
            else ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      OpcOp, Opc64Im: begin
        r.info.is_word = (opc == Opc64Im);
        rd_writes      = 1'b1;
        if (f7 == 7'b0000001) begin
          r.info.fu    = FuMdu;
          r.info.micop = {2'b00, f3};
          // Word forms exist only for mul/div/divu/rem/remu.
          ill = ill | ((opc == Opc64Im) && (f3 inside {3'd1, 3'd2, 3'd3}));
        end else begin
          r.info.fu = FuAlu;
          if (f7 == 7'd0) begin
            r.info.micop = alu_op(f3);
            ill = ill | ((opc == Opc64Im) && !(f3 inside {3'd0, 3'd1, 3'd5}));
          end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
            r.info.micop = MicSub;
          end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
            r.info.micop = MicSra;
          end else begin
            ill = 1'b1;
          end
        end
      end
      OpcMiscMem: begin
        r.info.fu = FuNop;
        ill       = ill | (f3[2:1] != 2'b00);
      end
      OpcSystem: begin
        if (f3 == 3'd0) begin
          if (inst == 32'h0000_0073) is_ecall = 1'b1;
          else if (inst == 32'h0010_0073) is_ebreak = 1'b1;
          else ill = 1'b1;
        end else if (f3 == 3'd4) begin
          ill = 1'b1;
        end else begin
          r.info.fu      = FuMisc;
          r.info.micop   = MicCsrrw + {3'b000, f3[1:0]} - 5'd1;
          r.info.use_imm = f3[2];
          r.info.csr_en  = 1'b1;
          r.info.csr_idx = imm_i;
          rd_writes      = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase

    r.info.rd_wen = rd_writes && (inst[11:7] != 5'd0);

    if (ill) begin
      r.exc  = 1'b1;
      r.code = 2'd0;
    end else if (is_ecall) begin
      r.exc  = 1'b1;
      r.code = 2'd1;
    end else if (is_ebreak) begin
      r.exc  = 1'b1;
      r.code = 2'd2;
    end

    // Excepting lane carries only its pc downstream.
    if (r.exc) begin
      r.info    = '0;
      r.info.pc = pc;
    end
    return r;
  endfunction

  bundle_t             bundle_d;
  bundle_t             mem_q [BUF_DEPTH];
  bundle_t             head;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                o_valid;
  logic                push, pop;

  always_comb begin
    lane_t ld;
    logic  found;
    bundle_d      = '0;
    bundle_d.mask = bus.if_vld_mask;
    found         = 1'b0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      ld               = decode_lane(bus.if_inst[i*32 +: 32], bus.if_pc[i*PCDEF +: PCDEF]);
      bundle_d.info[i] = ld.info;
      if (found) begin
        bundle_d.mask[i] = 1'b0;
      end else if (bus.if_vld_mask[i] && ld.exc) begin
        found              = 1'b1;
        bundle_d.exc_valid = 1'b1;
        bundle_d.exc_lane  = LaneW'(i);
        bundle_d.exc_code  = ld.code;
      end
    end
  end

  // Ready depends only on state, rst and flush; a pop does not free space the same cycle.
  assign bus.if_ready = !rst && !i_flush && (count_q < CntW'(BUF_DEPTH));
  assign push         = bus.if_valid && bus.if_ready;
  assign o_valid      = (count_q != '0);
  assign pop          = o_valid && bus.o_ready;
  assign head         = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bundle_d;
  end

  assign bus.o_valid     = o_valid;
  assign bus.o_vld_mask  = o_valid ? head.mask      : '0;
  assign bus.o_decinfo   = o_valid ? head.info      : '0;
  assign bus.o_exc_valid = o_valid ? head.exc_valid : 1'b0;
  assign bus.o_exc_lane  = o_valid ? head.exc_lane  : '0;
  assign bus.o_exc_code  = o_valid ? head.exc_code  : 2'd0;

endmodule

// File: tb/tb_decode_multilane.sv
module tb_decode_multilane;
  localparam int DW    = 4;
  localparam int PCW   = 64;
  localparam int DEC_W = PCW + 59;

  localparam logic [2:0] FU_NONE = 3'd0, FU_ALU = 3'd1, FU_MDU = 3'd2, FU_LDU = 3'd3;
  localparam logic [2:0] FU_STU = 3'd4, FU_MISC = 3'd5, FU_MV = 3'd6, FU_NOP = 3'd7;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [2:0]     fu;
    logic [4:0]     micop;
    logic           is_word;
    logic           use_imm;
    logic [4:0]     rd;
    logic           rd_wen;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [19:0]    imm20;
    logic           csr_en;
    logic [11:0]    csr_idx;
  } dec_t;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fu;
    logic [4:0]  micop;
    logic        wen;
    logic        chk_imm;
    logic [19:0] imm;
    logic        csr_en;
    logic [11:0] csr_idx;
    logic        exc;
    logic [1:0]  code;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  decode_multilane_if #(.DECODE_WIDTH(DW), .PCDEF(PCW)) bus ();

  decode_multilane #(.DECODE_WIDTH(DW), .BUF_DEPTH(2), .PCDEF(PCW)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_flush),
    .bus     (bus)
  );

  dec_t od [DW];
  for (genvar g = 0; g < DW; g++) begin : g_lane
    assign od[g] = bus.o_decinfo[g*DEC_W +: DEC_W];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] mask, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] i2, input logic [31:0] i3);
    bus.if_vld_mask = mask;
    bus.if_inst     = {i3, i2, i1, i0};
    for (int i = 0; i < DW; i++) bus.if_pc[i*PCW +: PCW] = 64'h1000 + 64'(4 * i);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_o_valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, "_mask"}, 64'(bus.o_vld_mask), 64'd0);
    chk({tag, "_exc_valid"}, 64'(bus.o_exc_valid), 64'd0);
    chk({tag, "_exc_lane"}, 64'(bus.o_exc_lane), 64'd0);
    chk({tag, "_exc_code"}, 64'(bus.o_exc_code), 64'd0);
    chk({tag, "_decinfo_zero"}, 64'(bus.o_decinfo != '0), 64'd0);
  endtask

  vec_t vecs [22];
  dec_t snap;

  initial begin
    vecs[0]  = '{32'h003100B3, FU_ALU,  5'd0,  1'b1, 1'b0, 20'h0,     1'b0, 12'h0,   1'b0, 2'd0};
    vecs[1]  = '{32'h403100B3, FU_ALU,  5'd1,  1'b1, 1'b0, 20'h0,     1'b0, 12'h0,   1'b0, 2'd0};
    vecs[2]  = '{32'h023100B3, FU_MDU,  5'd0,  1'b1, 1'b0, 20'h0,     1'b0, 12'h0,   1'b0, 2'd0};
    vecs[3]  = '{32'h023150BB, FU_MDU,  5'd5,  1'b1, 1'b0, 20'h0,     1'b0, 12'h0,   1'b0, 2'd0};
    vecs[4]  = '{32'hFF813283, FU_LDU,  5'd3,  1'b1, 1'b1, 20'hFFFF8, 1'b0, 12'h0,   1'b0, 2'd0};
    vecs[5]  = '{32'h00313823, FU_STU,  5'd3,  1'b0, 1'b1, 20'h00010, 1'b0, 12'h0,   1'b0, 2'd0};
    vecs[6]  = '{32'h12345237, FU_MISC, 5'd16, 1'b1, 1'b1, 20'h12345, 1'b0, 12'h0,   1'b0, 2'd0};
    vecs[7]  = '{32'hFFFFF017, FU_MISC, 5'd17, 1'b0, 1'b1, 20'hFFFFF, 1'b0, 12'h0,   1'b0, 2'd0};
    vecs[8]  = '{32'h004280E7, FU_MISC, 5'd19, 1'b1, 1'b1, 20'h00004, 1'b0, 12'h0,   1'b0, 2'd0};
    vecs[9]  = '{32'h0020E463, FU_ALU,  5'd12, 1'b0, 1'b1, 20'h00004, 1'b0, 12'h001, 1'b0, 2'd0};
    vecs[10] = '{32'h300021F3, FU_MISC, 5'd21, 1'b1, 1'b0, 20'h0,     1'b1, 12'h300, 1'b0, 2'd0};
    vecs[11] = '{32'h3402D073, FU_MISC, 5'd20, 1'b0, 1'b0, 20'h0,     1'b1, 12'h340, 1'b0, 2'd0};
    vecs[12] = '{32'h0FF0000F, FU_NOP,  5'd0,  1'b0, 1'b0, 20'h0,     1'b0, 12'h0,   1'b0, 2'd0};
    vecs[13] = '{32'h00000013, FU_NOP,  5'd0,  1'b0, 1'b1, 20'h0,     1'b0, 12'h0,   1'b0, 2'd0};
    vecs[14] = '{32'h00030293, FU_MV,   5'd0,  1'b1, 1'b1, 20'h0,     1'b0, 12'h0,   1'b0, 2'd0};
    vecs[15] = '{32'hFFF30293, FU_ALU,  5'd0,  1'b1, 1'b1, 20'hFFFFF, 1'b0, 12'h0,   1'b0, 2'd0};
    vecs[16] = '{32'h40315093, FU_ALU,  5'd7,  1'b1, 1'b1, 20'h00403, 1'b0, 12'h0,   1'b0, 2'd0};
    vecs[17] = '{32'h00100073, FU_NONE, 5'd0,  1'b0, 1'b0, 20'h0,     1'b0, 12'h0,   1'b1, 2'd2};
    vecs[18] = '{32'h00000073, FU_NONE, 5'd0,  1'b0, 1'b0, 20'h0,     1'b0, 12'h0,   1'b1, 2'd1};
    vecs[19] = '{32'h403110B3, FU_NONE, 5'd0,  1'b0, 1'b0, 20'h0,     1'b0, 12'h0,   1'b1, 2'd0};
    vecs[20] = '{32'h00004501, FU_NONE, 5'd0,  1'b0, 1'b0, 20'h0,     1'b0, 12'h0,   1'b1, 2'd0};
    vecs[21] = '{32'h0020A063, FU_NONE, 5'd0,  1'b0, 1'b0, 20'h0,     1'b0, 12'h0,   1'b1, 2'd0};

    bus.if_valid = 1'b0;
    bus.o_ready  = 1'b0;
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);

    // 1) reset, then the nop/mv/add/lui bundle
    step();
    chk("rst_if_ready", 64'(bus.if_ready), 64'd0);
    chk_idle("rst");
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_if_ready", 64'(bus.if_ready), 64'd1);
    drive(4'b1111, 32'h00028293, 32'h00038313, 32'h003100B3, 32'h12345237);
    bus.if_valid = 1'b1;
    step();
    bus.if_valid = 1'b0;
    chk("t1_o_valid", 64'(bus.o_valid), 64'd1);
    chk("t1_mask", 64'(bus.o_vld_mask), 64'hF);
    chk("t1_fu0", 64'(od[0].fu), 64'(FU_NOP));
    chk("t1_fu1", 64'(od[1].fu), 64'(FU_MV));
    chk("t1_fu2", 64'(od[2].fu), 64'(FU_ALU));
    chk("t1_fu3", 64'(od[3].fu), 64'(FU_MISC));
    chk("t1_imm3", 64'(od[3].imm20), 64'h12345);
    chk("t1_wen0", 64'(od[0].rd_wen), 64'd0);
    chk("t1_wen1", 64'(od[1].rd_wen), 64'd1);
    chk("t1_pc2", od[2].pc, 64'h1008);
    chk("t1_exc", 64'(bus.o_exc_valid), 64'd0);
    bus.o_ready = 1'b1;
    step();
    chk("t1_drained", 64'(bus.o_valid), 64'd0);

    // Table-driven single-lane decode vectors
    for (int i = 0; i < 22; i++) begin
      drive(4'b0001, vecs[i].inst, 32'h0, 32'h0, 32'h0);
      bus.if_valid = 1'b1;
      step();
      bus.if_valid = 1'b0;
      chk($sformatf("v%0d_o_valid", i), 64'(bus.o_valid), 64'd1);
      chk($sformatf("v%0d_mask", i), 64'(bus.o_vld_mask), 64'd1);
      chk($sformatf("v%0d_exc", i), 64'(bus.o_exc_valid), 64'(vecs[i].exc));
      chk($sformatf("v%0d_code", i), 64'(bus.o_exc_code), vecs[i].exc ? 64'(vecs[i].code) : 64'd0);
      chk($sformatf("v%0d_fu", i), 64'(od[0].fu), 64'(vecs[i].fu));
      chk($sformatf("v%0d_micop", i), 64'(od[0].micop), 64'(vecs[i].micop));
      chk($sformatf("v%0d_wen", i), 64'(od[0].rd_wen), 64'(vecs[i].wen));
      if (vecs[i].chk_imm) chk($sformatf("v%0d_imm", i), 64'(od[0].imm20), 64'(vecs[i].imm));
      chk($sformatf("v%0d_csr_en", i), 64'(od[0].csr_en), 64'(vecs[i].csr_en));
      chk($sformatf("v%0d_csr_idx", i), 64'(od[0].csr_idx), 64'(vecs[i].csr_idx));
      step();
    end
    chk("vec_drained", 64'(bus.o_valid), 64'd0);

    // 2) backpressure: fill, hold a third bundle, then drain in order
    bus.o_ready = 1'b0;
    drive(4'b0011, 32'h003100B3, 32'h403100B3, 32'h0, 32'h0);
    bus.if_valid = 1'b1;
    step();
    chk("t2_ready_after1", 64'(bus.if_ready), 64'd1);
    drive(4'b0001, 32'h12345237, 32'h0, 32'h0, 32'h0);
    step();
    drive(4'b0111, 32'h023100B3, 32'hFF813283, 32'h00313823, 32'h0);
    #1;
    chk("t2_full_not_ready", 64'(bus.if_ready), 64'd0);
    snap = od[1];
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("t2_stall%0d_mask", c), 64'(bus.o_vld_mask), 64'h3);
      chk($sformatf("t2_stall%0d_lane1", c), 64'(od[1] != snap), 64'd0);
      chk($sformatf("t2_stall%0d_micop", c), 64'(od[1].micop), 64'd1);
    end
    bus.o_ready = 1'b1;
    #1;
    chk("t2_full_pop_not_ready", 64'(bus.if_ready), 64'd0);
    step();
    chk("t2_b_mask", 64'(bus.o_vld_mask), 64'h1);
    chk("t2_b_fu", 64'(od[0].fu), 64'(FU_MISC));
    chk("t2_b_ready", 64'(bus.if_ready), 64'd1);
    step();
    bus.if_valid = 1'b0;
    chk("t2_c_mask", 64'(bus.o_vld_mask), 64'h7);
    chk("t2_c_fu0", 64'(od[0].fu), 64'(FU_MDU));
    chk("t2_c_fu2", 64'(od[2].fu), 64'(FU_STU));
    step();
    chk("t2_drained", 64'(bus.o_valid), 64'd0);

    // 3) truncation at an illegal lane; an excepting lane outside the mask is ignored
    drive(4'b1111, 32'h003100B3, 32'h00000000, 32'h00000073, 32'h003100B3);
    bus.if_valid = 1'b1;
    step();
    chk("t3_mask", 64'(bus.o_vld_mask), 64'h3);
    chk("t3_exc", 64'(bus.o_exc_valid), 64'd1);
    chk("t3_lane", 64'(bus.o_exc_lane), 64'd1);
    chk("t3_code", 64'(bus.o_exc_code), 64'd0);
    chk("t3_fu1", 64'(od[1].fu), 64'(FU_NONE));
    drive(4'b0011, 32'h003100B3, 32'h003100B3, 32'h00000073, 32'h0);
    step();
    bus.if_valid = 1'b0;
    chk("t3b_mask", 64'(bus.o_vld_mask), 64'h3);
    chk("t3b_exc", 64'(bus.o_exc_valid), 64'd0);
    step();

    // 4) branch / jump immediates
    drive(4'b0011, 32'h80000063, 32'h002000EF, 32'h0, 32'h0);
    bus.if_valid = 1'b1;
    step();
    bus.if_valid = 1'b0;
    chk("t4_beq_imm", 64'(od[0].imm20), 64'hFF800);
    chk("t4_beq_micop", 64'(od[0].micop), 64'd10);
    chk("t4_jal_imm", 64'(od[1].imm20), 64'h00001);
    chk("t4_jal_micop", 64'(od[1].micop), 64'd18);
    chk("t4_jal_wen", 64'(od[1].rd_wen), 64'd1);
    step();

    // 5) flush while full with an incoming bundle
    bus.o_ready = 1'b0;
    drive(4'b0001, 32'h003100B3, 32'h0, 32'h0, 32'h0);
    bus.if_valid = 1'b1;
    step();
    step();
    chk("t5_full", 64'(bus.o_valid), 64'd1);
    i_flush = 1'b1;
    #1;
    chk("t5_flush_not_ready", 64'(bus.if_ready), 64'd0);
    step();
    i_flush = 1'b0;
    bus.if_valid = 1'b0;
    #1;
    chk("t5_ready", 64'(bus.if_ready), 64'd1);
    chk_idle("t5");
    step();
    chk("t5_still_empty", 64'(bus.o_valid), 64'd0);
    bus.o_ready = 1'b1;
    drive(4'b0001, 32'h12345237, 32'h0, 32'h0, 32'h0);
    bus.if_valid = 1'b1;
    step();
    bus.if_valid = 1'b0;
    chk("t5_after_fu", 64'(od[0].fu), 64'(FU_MISC));
    chk("t5_after_imm", 64'(od[0].imm20), 64'h12345);
    step();
    chk("t5_after_drained", 64'(bus.o_valid), 64'd0);

    // 6) reset mid-stream
    bus.o_ready = 1'b0;
    drive(4'b1111, 32'h00028293, 32'h00038313, 32'h003100B3, 32'h12345237);
    bus.if_valid = 1'b1;
    step();
    bus.if_valid = 1'b0;
    chk("t6_valid_before", 64'(bus.o_valid), 64'd1);
    rst = 1'b1;
    step();
    chk("t6_if_ready", 64'(bus.if_ready), 64'd0);
    chk_idle("t6");
    rst = 1'b0;
    #1;
    chk("t6_ready_after", 64'(bus.if_ready), 64'd1);
    step();
    chk("t6_empty_after", 64'(bus.o_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
